// File: rtl/gesture_matcher_if.sv
// rtl/gesture_matcher_if.sv - sample, flash and result bus bundle for gesture_matcher
interface gesture_matcher_if;
    logic        sample_valid;
    logic [63:0] sample_data;
    logic        sample_ready;
    logic [63:0] mem_addr;
    logic        mem_ce_n;
    logic        mem_oe;
    logic        mem_rw;
    logic [63:0] mem_data;
    logic        mem_busy_off;
    logic        result_valid;
    logic [5:0]  result_idx;
    logic        result_match;
    logic        result_err;

    modport master (
        input  sample_valid, sample_data, mem_data, mem_busy_off,
        output sample_ready, mem_addr, mem_ce_n, mem_oe, mem_rw,
               result_valid, result_idx, result_match, result_err
    );

    modport slave (
        output sample_valid, sample_data, mem_data, mem_busy_off,
        input  sample_ready, mem_addr, mem_ce_n, mem_oe, mem_rw,
               result_valid, result_idx, result_match, result_err
    );
endinterface

// File: rtl/gesture_matcher.sv
// rtl/gesture_matcher.sv - nearest-template gesture matcher scanning a flash template table
module gesture_matcher #(
    parameter int NUM_ENTRIES = 37,
    parameter int TOL         = 16,
    parameter int TIMEOUT     = 64
) (
    input logic               clk,
    input logic               rst,
    gesture_matcher_if.master bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int              WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [5:0]      LAST_IDX  = 6'(NUM_ENTRIES - 1);
    localparam logic [7:0]      TOL_L     = 8'(TOL);
    localparam logic [5:0]      NO_MATCH  = 6'h3F;
    localparam logic [10:0]     SAD_INIT  = 11'h7FF;

    logic [2:0]     state;
    logic [63:0]    sample_q;
    logic [63:0]    tmpl_q;
    logic [5:0]     idx;
    logic [5:0]     best_idx;
    logic [10:0]    best_sad;
    logic           found;
    logic [WCW-1:0] wait_cnt;

    logic           sample_ready_q;
    logic [5:0]     mem_addr_q;
    logic           mem_ce_n_q;
    logic           mem_oe_q;
    logic           mem_rw_q;
    logic           result_valid_q;
    logic [5:0]     result_idx_q;
    logic           result_match_q;
    logic           result_err_q;

    logic [7:0]     diff [8];
    logic [10:0]    sad;
    logic           qual;
    logic           better;
    logic [5:0]     idx_inc;

    assign bus.sample_ready = sample_ready_q;
    assign bus.mem_addr     = {58'd0, mem_addr_q};
    assign bus.mem_ce_n     = mem_ce_n_q;
    assign bus.mem_oe       = mem_oe_q;
    assign bus.mem_rw       = mem_rw_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_idx   = result_idx_q;
    assign bus.result_match = result_match_q;
    assign bus.result_err   = result_err_q;

    // Per-channel absolute difference, sum of differences, and the tolerance gate.
    always_comb begin
        sad  = '0;
        qual = 1'b1;
        for (int k = 0; k < 8; k++) begin
            diff[k] = (sample_q[8*k +: 8] >= tmpl_q[8*k +: 8])
                    ? sample_q[8*k +: 8] - tmpl_q[8*k +: 8]
                    : tmpl_q[8*k +: 8] - sample_q[8*k +: 8];
            sad = sad + {3'b000, diff[k]};
            if (diff[k] > TOL_L) qual = 1'b0;
        end
    end

    // Strict less-than so an equal SAD at a higher index never displaces the earlier one.
    assign better  = qual && (sad < best_sad);
    assign idx_inc = idx + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sample_q       <= '0;
            tmpl_q         <= '0;
            idx            <= '0;
            best_idx       <= '0;
            best_sad       <= SAD_INIT;
            found          <= 1'b0;
            wait_cnt       <= '0;
            sample_ready_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_ce_n_q     <= 1'b1;
            mem_oe_q       <= 1'b0;
            mem_rw_q       <= 1'b1;
            result_valid_q <= 1'b0;
            result_idx_q   <= NO_MATCH;
            result_match_q <= 1'b0;
            result_err_q   <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            mem_rw_q       <= 1'b1;
            case (state)
                ST_IDLE: begin
                    sample_ready_q <= 1'b1;
                    if (bus.sample_valid && sample_ready_q) begin
                        sample_q       <= bus.sample_data;
                        idx            <= '0;
                        best_idx       <= '0;
                        best_sad       <= SAD_INIT;
                        found          <= 1'b0;
                        sample_ready_q <= 1'b0;
                        mem_addr_q     <= '0;
                        mem_ce_n_q     <= 1'b0;
                        mem_oe_q       <= 1'b1;
                        state          <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_busy_off) begin
                        tmpl_q     <= bus.mem_data;
                        mem_ce_n_q <= 1'b1;
                        mem_oe_q   <= 1'b0;
                        state      <= ST_CMP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Flash never came ready: abandon the scan and report an error.
                        mem_ce_n_q     <= 1'b1;
                        mem_oe_q       <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_idx_q   <= NO_MATCH;
                        result_match_q <= 1'b0;
                        result_err_q   <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CMP: begin
                    if (better) begin
                        best_sad <= sad;
                        best_idx <= idx;
                        found    <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        // Result registers take this entry's comparison into account directly.
                        result_valid_q <= 1'b1;
                        result_err_q   <= 1'b0;
                        if (better) begin
                            result_idx_q   <= idx;
                            result_match_q <= 1'b1;
                        end else if (found) begin
                            result_idx_q   <= best_idx;
                            result_match_q <= 1'b1;
                        end else begin
                            result_idx_q   <= NO_MATCH;
                            result_match_q <= 1'b0;
                        end
                        state <= ST_DONE;
                    end else begin
                        idx        <= idx_inc;
                        mem_addr_q <= idx_inc;
                        mem_ce_n_q <= 1'b0;
                        mem_oe_q   <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    sample_ready_q <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: begin
                    mem_ce_n_q <= 1'b1;
                    mem_oe_q   <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gesture_matcher.sv
// tb/tb_gesture_matcher.sv - directed scoreboard bench for gesture_matcher
module tb_gesture_matcher;
    typedef struct {
        logic [5:0] idx;
        logic       match;
        logic       err;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy_off = 1'b1;
    logic [63:0] rom [64];
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    gesture_matcher_if bus ();

    gesture_matcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mem_data     = (!bus.mem_ce_n && bus.mem_oe) ? rom[bus.mem_addr[5:0]] : 64'h0;
    assign bus.mem_busy_off = busy_off;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rom();
        for (int i = 0; i < 64; i++) rom[i] = {8{8'hC0}};
        rom[5] = {8{8'h40}};
    endtask

    // Called at a negedge; returns at the negedge one cycle after result_valid.
    task automatic run_scan(input string tag, input logic [63:0] smp, input logic [5:0] e_idx,
                            input logic e_match, input logic e_err, input int e_lat,
                            input int low_n, input logic stuck, input logic keep_valid,
                            output int acc_wait);
        exp_t e;
        exp_t got;
        int   cnt;
        bus.sample_data  = smp;
        bus.sample_valid = 1'b1;
        busy_off         = !stuck;
        acc_wait         = 0;
        while (!bus.sample_ready && acc_wait < 200) begin
            @(negedge clk);
            acc_wait++;
        end
        check({tag, "_ready"}, 64'(bus.sample_ready), 64'd1);
        e.idx = e_idx; e.match = e_match; e.err = e_err; e.lat = e_lat;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus.sample_valid = 1'b0;
        check({tag, "_first_req"}, {57'd0, bus.mem_ce_n, bus.mem_addr[5:0]}, 64'd0);
        cnt = 0;
        while (!bus.result_valid && cnt < 400) begin
            busy_off = stuck ? 1'b0 : !(cnt >= 1 && cnt <= low_n);
            @(negedge clk);
            cnt++;
        end
        busy_off = 1'b1;
        check({tag, "_valid"}, 64'(bus.result_valid), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            check({tag, "_latency"}, 64'(cnt), 64'(got.lat));
            check({tag, "_idx"}, 64'(bus.result_idx), 64'(got.idx));
            check({tag, "_match"}, 64'(bus.result_match), 64'(got.match));
            check({tag, "_err"}, 64'(bus.result_err), 64'(got.err));
            check({tag, "_rw"}, 64'(bus.mem_rw), 64'd1);
        end
        @(negedge clk);
        check({tag, "_pulse_idle"}, {62'd0, bus.result_valid, bus.sample_ready}, 64'd1);
    endtask

    initial begin
        int   w;
        int   n;
        logic extra;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        set_rom();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.sample_ready), 64'd0);
        check("rst_bus", {bus.mem_ce_n, bus.mem_oe, bus.mem_rw, bus.mem_addr[60:0]}, 64'h8000_0000_0000_0000 | 64'h2000_0000_0000_0000);
        check("rst_result", {55'd0, bus.result_valid, bus.result_idx, bus.result_match, bus.result_err},
              {55'd0, 1'b0, 6'h3F, 1'b0, 1'b0});
        check("rst_addr_hi", bus.mem_addr, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", 64'(bus.sample_ready), 64'd1);

        run_scan("t1_exact", {8{8'h40}}, 6'd5, 1'b1, 1'b0, 111, 0, 1'b0, 1'b0, w);
        run_scan("t2_tol16", {{7{8'h40}}, 8'h50}, 6'd5, 1'b1, 1'b0, 111, 0, 1'b0, 1'b0, w);
        run_scan("t2_tol17", {{7{8'h40}}, 8'h51}, 6'h3F, 1'b0, 1'b0, 111, 0, 1'b0, 1'b0, w);

        for (int i = 0; i < 64; i++) rom[i] = {8{8'hC0}};
        rom[3] = {8{8'h20}};
        rom[9] = {8{8'h20}};
        run_scan("t3_tie", {8{8'h22}}, 6'd3, 1'b1, 1'b0, 111, 0, 1'b0, 1'b0, w);
        rom[12] = {8{8'h21}};
        run_scan("t3_better", {8{8'h22}}, 6'd12, 1'b1, 1'b0, 111, 0, 1'b0, 1'b0, w);

        set_rom();
        run_scan("t4_slow", {8{8'h40}}, 6'd5, 1'b1, 1'b0, 121, 10, 1'b0, 1'b0, w);
        run_scan("t4_timeout", {8{8'h40}}, 6'h3F, 1'b0, 1'b1, 65, 0, 1'b1, 1'b0, w);

        // Reset in the middle of a scan.
        bus.sample_data  = {8{8'h40}};
        bus.sample_valid = 1'b1;
        n = 0;
        while (!bus.sample_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        n = 0;
        while (bus.mem_addr != 64'd20 && n < 200) begin @(negedge clk); n++; end
        check("t5_reach_addr20", bus.mem_addr, 64'd20);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_bus", {61'd0, bus.mem_ce_n, bus.result_valid, bus.sample_ready}, 64'h4);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_ready_after", {62'd0, bus.sample_ready, bus.result_valid}, 64'h2);
        run_scan("t5_rescan", {8{8'h40}}, 6'd5, 1'b1, 1'b0, 111, 0, 1'b0, 1'b0, w);

        // sample_valid held high across two back-to-back scans.
        run_scan("t6_first", {8{8'h40}}, 6'd5, 1'b1, 1'b0, 111, 0, 1'b0, 1'b1, w);
        run_scan("t6_second", {{7{8'h40}}, 8'h51}, 6'h3F, 1'b0, 1'b0, 111, 0, 1'b0, 1'b0, w);
        check("t6_recapture_wait", 64'(w), 64'd0);
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (!bus.mem_ce_n || bus.result_valid) extra = 1'b1;
        end
        check("t6_no_extra_scan", 64'(extra), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
